// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target endpoint: word width, mode bit positions, FSM states.
package spi_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned CPOL_BIT = 1;
    localparam int unsigned CPHA_BIT = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchronizer: SYNC_STAGES flop chain plus a one-cycle-delayed copy for edge detection.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic sync,
    output logic edge_c
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync   = chain[SYNC_STAGES-1];
    assign edge_c = sync ^ prev;

endmodule

// File: rtl/spi_target.sv
// SPI target endpoint: oversamples SCLK/CS_n/MOSI, shifts 1-32 bit words MSB-first in all four
// CPOL/CPHA modes, popping TX words from and pushing RX words to show-ahead FIFOs.
module spi_target
    import spi_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES   = 2,
    parameter logic [WORD_W-1:0] UNDERRUN_WORD = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  wordSize,
    input  logic              TXEmpty,
    input  logic [WORD_W-1:0] DataIn,
    output logic              requestTXread,
    input  logic              RXFull,
    output logic              requestRXwrite,
    output logic [WORD_W-1:0] DataOuttoRXFifo,
    input  logic              clear_flags,
    output logic              busy,
    output logic              underrun,
    output logic              overrun,
    output logic              abort
);

    logic                   sclk_s, sclk_edge_c, cs_s, cs_edge_c, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_chain;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clock(clock), .reset(reset), .pin(sclk), .sync(sclk_s), .edge_c(sclk_edge_c)
    );

    // cs_n resets deselected so leaving reset never looks like a select.
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clock(clock), .reset(reset), .pin(cs_n), .sync(cs_s), .edge_c(cs_edge_c)
    );

    always_ff @(posedge clock) begin
        if (reset) mosi_chain <= '0;
        else       mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    state_t            state_q, state_n;
    logic [1:0]        mode_q, mode_n;
    logic [CNT_W-1:0]  ws_q, ws_n, bitcnt_q, bitcnt_n, load_ws;
    logic [WORD_W-1:0] shreg_q, shreg_n, rxreg_q, rxreg_n, rx_data_n;
    logic              load_pend_q, load_pend_n, got_bit_q, got_bit_n;
    logic              miso_n, tx_req_n, rx_req_n, load_c;
    logic              urun_set, orun_set, abort_set;
    logic              cpol_c, cpha_c, lead_c, trail_c, sample_c, shift_c, cs_fall_c, cs_rise_c;

    assign cpol_c    = mode_q[CPOL_BIT];
    assign cpha_c    = mode_q[CPHA_BIT];
    assign lead_c    = sclk_edge_c & (sclk_s != cpol_c);
    assign trail_c   = sclk_edge_c & (sclk_s == cpol_c);
    assign sample_c  = cpha_c ? trail_c : lead_c;
    assign shift_c   = cpha_c ? lead_c : trail_c;
    assign cs_fall_c = cs_edge_c & ~cs_s;
    assign cs_rise_c = cs_edge_c & cs_s;

    always_comb begin
        state_n     = state_q;
        mode_n      = mode_q;
        ws_n        = ws_q;
        bitcnt_n    = bitcnt_q;
        shreg_n     = shreg_q;
        rxreg_n     = rxreg_q;
        load_pend_n = load_pend_q;
        got_bit_n   = got_bit_q;
        miso_n      = miso;
        rx_data_n   = DataOuttoRXFifo;
        tx_req_n    = 1'b0;
        rx_req_n    = 1'b0;
        urun_set    = 1'b0;
        orun_set    = 1'b0;
        abort_set   = 1'b0;
        load_c      = 1'b0;
        load_ws     = ws_q;

        case (state_q)
            IDLE: begin
                miso_n = 1'b0;
                if (cs_fall_c) begin
                    state_n     = ACTIVE;
                    mode_n      = mode;
                    ws_n        = wordSize;
                    bitcnt_n    = wordSize;
                    rxreg_n     = '0;
                    got_bit_n   = 1'b0;
                    load_pend_n = mode[CPHA_BIT];
                    load_c      = ~mode[CPHA_BIT];
                    load_ws     = wordSize;
                end
            end
            ACTIVE: begin
                if (cs_rise_c) begin
                    state_n     = IDLE;
                    abort_set   = got_bit_q;
                    load_pend_n = 1'b0;
                    miso_n      = 1'b0;
                end else begin
                    if (sample_c) begin
                        rxreg_n[bitcnt_q] = mosi_s;
                        got_bit_n         = 1'b1;
                        if (bitcnt_q != '0) begin
                            bitcnt_n = bitcnt_q - CNT_W'(1);
                        end else begin
                            if (RXFull) begin
                                orun_set = 1'b1;
                            end else begin
                                rx_req_n  = 1'b1;
                                rx_data_n = rxreg_n;
                            end
                            rxreg_n     = '0;
                            bitcnt_n    = ws_q;
                            load_pend_n = 1'b1;
                            got_bit_n   = 1'b0;
                        end
                    end
                    if (shift_c) begin
                        if (load_pend_q) begin
                            load_c      = 1'b1;
                            load_pend_n = 1'b0;
                        end else begin
                            miso_n = shreg_q[bitcnt_q];
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Word load from the TX FIFO head, or the underrun filler when it is empty.
        if (load_c) begin
            if (!TXEmpty) begin
                shreg_n  = DataIn;
                tx_req_n = 1'b1;
            end else begin
                shreg_n  = UNDERRUN_WORD;
                urun_set = 1'b1;
            end
            miso_n = shreg_n[load_ws];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            mode_q          <= '0;
            ws_q            <= '0;
            bitcnt_q        <= '0;
            shreg_q         <= '0;
            rxreg_q         <= '0;
            load_pend_q     <= 1'b0;
            got_bit_q       <= 1'b0;
            miso            <= 1'b0;
            miso_oe         <= 1'b0;
            requestTXread   <= 1'b0;
            requestRXwrite  <= 1'b0;
            DataOuttoRXFifo <= '0;
            busy            <= 1'b0;
            underrun        <= 1'b0;
            overrun         <= 1'b0;
            abort           <= 1'b0;
        end else begin
            state_q         <= state_n;
            mode_q          <= mode_n;
            ws_q            <= ws_n;
            bitcnt_q        <= bitcnt_n;
            shreg_q         <= shreg_n;
            rxreg_q         <= rxreg_n;
            load_pend_q     <= load_pend_n;
            got_bit_q       <= got_bit_n;
            miso            <= miso_n;
            miso_oe         <= (state_n == ACTIVE);
            requestTXread   <= tx_req_n;
            requestRXwrite  <= rx_req_n;
            DataOuttoRXFifo <= rx_data_n;
            busy            <= (state_n != IDLE);
            // A same-cycle set wins over clear_flags.
            underrun        <= urun_set  | (underrun & ~clear_flags);
            overrun         <= orun_set  | (overrun  & ~clear_flags);
            abort           <= abort_set | (abort    & ~clear_flags);
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: an SPI master driven from tasks, FIFO models on both sides, and a
// word-level reference model of what should cross the link in each transfer.
module tb_spi_target;

    localparam int unsigned SYNC = 2;
    localparam int unsigned H    = 8;

    logic        clock = 1'b0;
    logic        reset, sclk, cs_n, mosi, miso, miso_oe;
    logic [1:0]  mode;
    logic [4:0]  wordSize;
    logic        TXEmpty = 1'b1;
    logic [31:0] DataIn  = 32'h0;
    logic        requestTXread, RXFull, requestRXwrite, clear_flags;
    logic [31:0] DataOuttoRXFifo;
    logic        busy, underrun, overrun, abort;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pops    = 0;
    int          pushes  = 0;
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic [31:0] txw[4];
    logic [31:0] rw[4];
    logic [31:0] obs[4];

    always #5 clock = ~clock;

    spi_target #(.SYNC_STAGES(SYNC), .UNDERRUN_WORD(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mode(mode), .wordSize(wordSize),
        .TXEmpty(TXEmpty), .DataIn(DataIn), .requestTXread(requestTXread),
        .RXFull(RXFull), .requestRXwrite(requestRXwrite), .DataOuttoRXFifo(DataOuttoRXFifo),
        .clear_flags(clear_flags), .busy(busy), .underrun(underrun), .overrun(overrun),
        .abort(abort)
    );

    // Show-ahead TX FIFO and RX FIFO capture.
    always @(negedge clock) begin
        logic [31:0] tmp;
        if (requestTXread) begin
            pops++;
            if (txq.size() > 0) tmp = txq.pop_front();
        end
        if (requestRXwrite) begin
            pushes++;
            rxq.push_back(DataOuttoRXFifo);
        end
        TXEmpty = (txq.size() == 0);
        DataIn  = (txq.size() == 0) ? 32'h0 : txq[0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One CS-framed transfer of nwords words; the TX FIFO holds the first nload entries of txw.
    // cut >= 0 deasserts CS after that many bits. In CPHA=0 the master returns SCLK to idle
    // together with the CS deassert, so the final trailing edge never starts another load.
    task automatic xfer(input logic [1:0] md, input int ws, input int nwords, input int nload,
                        input logic full, input int cut);
        logic [31:0] mask, exp_rx;
        int          p0, q0, nb;
        logic        cpol, cpha, stop;
        mask = 32'hFFFF_FFFF >> (31 - ws);
        cpol = md[1];
        cpha = md[0];
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        txq.delete();
        rxq.delete();
        for (int k = 0; k < nload; k++) txq.push_back(txw[k]);
        for (int k = 0; k < 4; k++) obs[k] = 32'h0;
        mode     = md;
        wordSize = 5'(ws);
        RXFull   = full;
        sclk     = cpol;
        mosi     = 1'b0;
        tick(H);
        p0   = pops;
        q0   = pushes;
        nb   = 0;
        stop = 1'b0;
        cs_n = 1'b0;
        tick(H);
        for (int k = 0; k < nwords; k++) begin
            for (int b = ws; b >= 0; b--) begin
                if (cut >= 0 && nb == cut) stop = 1'b1;
                if (!stop) begin
                    nb++;
                    if (!cpha) begin
                        mosi = rw[k][b];
                        tick(H);
                        obs[k][b] = miso;
                        sclk = ~cpol;
                        tick(H);
                        sclk = cpol;
                        if (cut < 0 && k == nwords - 1 && b == 0) cs_n = 1'b1;
                    end else begin
                        sclk = ~cpol;
                        mosi = rw[k][b];
                        tick(H);
                        obs[k][b] = miso;
                        sclk = cpol;
                        tick(H);
                    end
                end
            end
        end
        tick(H);
        cs_n = 1'b1;
        tick(H + 4);
        if (cut >= 0) begin
            check("abort_set", 32'(abort), 32'd1);
            check("abort_pushes", 32'(pushes - q0), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
        end else begin
            for (int k = 0; k < nwords; k++)
                check("miso_word", obs[k] & mask, (k < nload) ? (txw[k] & mask) : 32'h0);
            check("pops", 32'(pops - p0), 32'((nwords < nload) ? nwords : nload));
            check("pushes", 32'(pushes - q0), full ? 32'd0 : 32'(nwords));
            if (!full) begin
                for (int k = 0; k < nwords; k++) begin
                    exp_rx = rw[k] & mask;
                    check("rx_word", (k < rxq.size()) ? rxq[k] : 32'hxxxx_xxxx, exp_rx);
                end
            end
            check("underrun", 32'(underrun), 32'(nwords > nload));
            check("overrun", 32'(overrun), 32'(full));
            check("abort_clr", 32'(abort), 32'd0);
            check("busy_end", 32'({busy, miso_oe}), 32'd0);
        end
    endtask

    initial begin
        int p0, q0;
        reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; mode = 2'd0; wordSize = 5'd7;
        RXFull = 1'b0; clear_flags = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(2);
        check("reset_ctl", 32'({miso, miso_oe, requestTXread, requestRXwrite, busy,
                                underrun, overrun, abort}), 32'd0);
        check("reset_data", DataOuttoRXFifo, 32'h0);

        txw[0] = 32'hA5; rw[0] = 32'h3C;
        xfer(2'd0, 7, 1, 1, 1'b0, -1);

        for (int m = 0; m < 4; m++) begin
            txw[0] = 32'hDEADBEEF; rw[0] = 32'h12345678;
            xfer(2'(m), 31, 1, 1, 1'b0, -1);
        end

        txw[0] = 32'h1111; txw[1] = 32'h2222; rw[0] = 32'hABCD; rw[1] = 32'h1357;
        xfer(2'd0, 15, 2, 2, 1'b0, -1);

        // Reset in the middle of a word.
        txq.delete();
        txq.push_back(32'hF0F0_F0F0);
        mode = 2'd0; wordSize = 5'd7; RXFull = 1'b0; sclk = 1'b0;
        tick(H);
        p0 = pops; q0 = pushes;
        cs_n = 1'b0; tick(H);
        mosi = 1'b1; sclk = 1'b1; tick(H);
        sclk = 1'b0; tick(H);
        sclk = 1'b1; tick(H);
        check("busy_mid", 32'(busy), 32'd1);
        reset = 1'b1; cs_n = 1'b1; sclk = 1'b0;
        @(posedge clock);
        #1;
        check("rst_mid_ctl", 32'({miso, miso_oe, requestTXread, requestRXwrite, busy,
                                  underrun, overrun, abort}), 32'd0);
        check("rst_mid_data", DataOuttoRXFifo, 32'h0);
        tick(SYNC + 2);
        reset = 1'b0;
        tick(H);
        check("rst_pops", 32'(pops - p0), 32'd1);
        check("rst_pushes", 32'(pushes - q0), 32'd0);
        check("rst_flags", 32'({busy, underrun, overrun, abort}), 32'd0);

        rw[0] = 32'h5A;
        xfer(2'd0, 7, 1, 0, 1'b0, -1);
        clear_flags = 1'b1; tick(1); clear_flags = 1'b0;
        check("underrun_clear", 32'(underrun), 32'd0);

        txw[0] = 32'h96; rw[0] = 32'h69;
        xfer(2'd1, 7, 1, 1, 1'b1, -1);

        txw[0] = 32'hC3; rw[0] = 32'hFF;
        xfer(2'd0, 7, 1, 1, 1'b0, 3);

        for (int it = 0; it < 12; it++) begin
            int nw, nl, wsr;
            nw  = int'($urandom_range(1, 3));
            nl  = int'($urandom_range(0, nw));
            wsr = int'($urandom_range(0, 31));
            for (int k = 0; k < 4; k++) begin
                txw[k] = $urandom;
                rw[k]  = $urandom;
            end
            xfer(2'($urandom_range(0, 3)), wsr, nw, nl, ($urandom_range(0, 5) == 0), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
